// File: rtl/q_pkg.sv
// Shared types and defaults for the Q-flop capture path.
package q_pkg;

    localparam int Q_SYNC_STAGES_DEF = 2;
    localparam int Q_ARM_CYCLES_DEF  = 2;

    typedef enum logic [2:0] {
        ARM,
        SETTLE,
        WAIT_DONE,
        CAPTURE,
        STALL
    } q_cap_state_t;

endpackage

// File: rtl/q_sync_fifo.sv
// DEPTH x W synchronous FIFO with push/pop/count. The head word reads as
// zero while empty, so the output is clean straight out of reset.
module q_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_wdata,
    input  logic                     i_pop,
    output logic [W-1:0]             o_rdata,
    output logic                     o_valid,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;
    assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
    assign o_count = r_count;

    // Storage write; no reset needed since the read side is gated by o_valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks net push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/q_sync_capture.sv
// Clocked consumer of a self-timed q_flop bank: synchronizes bank-wide
// completion, captures the resolved word into a FIFO and re-arms the bank.
// Optional watchdog: define Q_SYNC_CAPTURE_TIMEOUT_EN to force a re-arm
// (and raise sticky err) when the bank fails to complete within TIMEOUT.
module q_sync_capture
    import q_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = Q_SYNC_STAGES_DEF,
    parameter int ARM_CYCLES  = Q_ARM_CYCLES_DEF,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           q_ack,
    input  logic [W-1:0]           q_out,
    output logic                   q_rst,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err
);

    localparam int ACW = $clog2(ARM_CYCLES + 1);

    q_cap_state_t           r_state;
    q_cap_state_t           w_next;
    logic [ACW-1:0]         r_arm_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_ack;
    logic                   w_push;
    logic                   w_full;
    logic                   w_to_hit;

    assign w_sync_ack = r_sync[SYNC_STAGES-1];
    // Held through reset itself so the bank is never left free-running.
    assign q_rst      = rst || (r_state == ARM);

    // Only the AND of all acks crosses the domain; q_out is sampled later,
    // once the bank is known to be holding it.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[SYNC_STAGES-2:0], &q_ack};
    end

`ifdef Q_SYNC_CAPTURE_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] r_to_cnt;

    // Watchdog runs only while waiting on the bank; clears everywhere else.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (r_state == SETTLE || r_state == WAIT_DONE) r_to_cnt <= r_to_cnt + 1'b1;
            else                                           r_to_cnt <= '0;
            if (w_to_hit) err <= 1'b1;
        end
    end

    assign w_to_hit = (r_state == SETTLE || r_state == WAIT_DONE) &&
                      (r_to_cnt == TCW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_to_hit         = 1'b0;
    assign err              = 1'b0;
`endif

    // State register plus arm-pulse length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARM;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_arm_cnt <= (r_state == ARM && w_next == ARM) ? r_arm_cnt + 1'b1 : '0;
        end
    end

    // Next-state logic; a watchdog hit overrides everything and drops the sample.
    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        case (r_state)
            ARM:       if (r_arm_cnt == ACW'(ARM_CYCLES - 1)) w_next = SETTLE;
            SETTLE:    if (!w_sync_ack) w_next = WAIT_DONE;
            WAIT_DONE: if (w_sync_ack) w_next = w_full ? STALL : CAPTURE;
            CAPTURE: begin
                w_push = 1'b1;
                w_next = ARM;
            end
            STALL:     if (!w_full) w_next = CAPTURE;
            default:   w_next = ARM;
        endcase
        if (w_to_hit) w_next = ARM;
    end

    q_sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (q_out),
        .i_pop   (out_ready),
        .o_rdata (out_data),
        .o_valid (out_valid),
        .o_full  (w_full),
        .o_count (count)
    );

endmodule

// File: tb/tb_q_sync_capture.sv
// Bench for q_sync_capture: behavioural q_flop bank plus a scoreboard of
// expected captured words, checked whenever the consumer pops a word.
module tb_q_sync_capture;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] q_ack;
    logic [W-1:0] q_out;
    logic         q_rst;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   count;
    logic         err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] bank_q[$];
    logic [W-1:0] ack_mask   = '1;
    int           bank_delay = 40;

    always #5 clk = ~clk;

    q_sync_capture #(.W(W), .DEPTH(DEPTH), .SYNC_STAGES(2), .ARM_CYCLES(2), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_ack     (q_ack),
        .q_out     (q_out),
        .q_rst     (q_rst),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .err       (err)
    );

    // Bank model: after q_rst falls, waits bank_delay cycles, presents the next
    // queued word and raises ack (masked), holding it until q_rst rises again.
    initial begin : bank
        int   waitc;
        logic fired;
        waitc = 0;
        fired = 1'b0;
        q_ack = '0;
        q_out = '0;
        forever begin
            @(posedge clk);
            #3;
            if (q_rst) begin
                fired = 1'b0;
                waitc = 0;
            end else if (!fired && bank_q.size() > 0) begin
                if (waitc >= bank_delay) begin
                    q_out = bank_q.pop_front();
                    fired = 1'b1;
                end else begin
                    waitc++;
                end
            end
            q_ack = fired ? ack_mask : '0;
        end
    end

    // One clock: scoreboard check at the negedge for any pop about to happen,
    // then return 1ns after the next rising edge (input drive / sample point).
    task automatic tick();
        logic [W-1:0] w;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected got=%h expected=<none>", out_data);
            end else begin
                w = exp_q.pop_front();
                if (out_data !== w) begin
                    errors++;
                    $display("FAIL pop_data got=%h expected=%h", out_data, w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(3);
        checks++; if (q_rst !== 1'b1)    begin errors++; $display("FAIL reset_q_rst got=%b expected=1", q_rst); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b expected=0", out_valid); end
        checks++; if (count !== 3'd0)    begin errors++; $display("FAIL reset_count got=%0d expected=0", count); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h expected=00", out_data); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got=%b expected=0", err); end
    endtask

    task automatic test_basic();
        int n;
        bit seen;
        out_ready  = 1'b0;
        bank_delay = 40;
        bank_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && q_rst === 1'b1; i++) begin n++; tick(); end
        checks++; if (n != 2) begin errors++; $display("FAIL arm_after_reset got=%0d cycles expected=2", n); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (q_ack === 8'hFF) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL bank_ack_timeout got=none expected=ack"); end
        // Ack is asserted mid-cycle, so one rising edge has already followed it here.
        n = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); n++; if (out_valid === 1'b1) begin seen = 1; break; end end
        checks++; if (!seen || n != 4) begin errors++; $display("FAIL ack_to_valid got=%0d expected=4", n); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h expected=a5", out_data); end
        checks++; if (count !== 3'd1)     begin errors++; $display("FAIL basic_count got=%0d expected=1", count); end
        n = 0;
        for (int i = 0; i < 10 && q_rst === 1'b1; i++) begin n++; tick(); end
        checks++; if (n != 2) begin errors++; $display("FAIL rearm_pulse got=%0d cycles expected=2", n); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL basic_drain got=%0d expected=0", count); end
    endtask

    task automatic test_stall();
        bit seen;
        out_ready  = 1'b0;
        bank_delay = 3;
        for (int i = 1; i <= 5; i++) begin
            bank_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        seen = 0;
        for (int i = 0; i < 500; i++) begin tick(); if (count === 3'd4) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL stall_fill got=%0d expected=4", count); end
        ticks(20);
        checks++; if (count !== 3'd4)  begin errors++; $display("FAIL stall_count got=%0d expected=4", count); end
        checks++; if (q_rst !== 1'b0)  begin errors++; $display("FAIL stall_q_rst got=%b expected=0", q_rst); end
        checks++; if (q_ack !== 8'hFF) begin errors++; $display("FAIL stall_bank_hold got=%h expected=ff", q_ack); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (count === 3'd4) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL stall_resume got=%0d expected=4", count); end
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (exp_q.size() == 0 && count === 3'd0) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL stall_drain got=%0d left expected=0", exp_q.size()); end
        out_ready = 1'b0;
    endtask

    task automatic test_partial_ack();
        bit seen;
        out_ready  = 1'b1;
        bank_delay = 2;
        ack_mask   = 8'h7F;
        bank_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        seen = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (q_ack === 8'h7F) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL partial_ack_start got=%h expected=7f", q_ack); end
        ticks(30);
        checks++; if (count !== 3'd0 || exp_q.size() != 1)
            begin errors++; $display("FAIL partial_no_capture got=%0d expected=0", count); end
        ack_mask = 8'hFF;
        seen = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (exp_q.size() == 0) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL partial_full_capture got=none expected=3c"); end
        out_ready = 1'b0;
        ticks(5);
    endtask

    task automatic test_reset_capture();
        bit seen;
        out_ready  = 1'b0;
        bank_delay = 2;
        bank_q.push_back(8'h5A);
        seen = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (q_ack === 8'hFF) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL rstcap_ack got=none expected=ack"); end
        ticks(2);
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstcap_valid got=%b expected=0", out_valid); end
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rstcap_count got=%0d expected=0", count); end
        checks++; if (q_rst !== 1'b1)     begin errors++; $display("FAIL rstcap_q_rst got=%b expected=1", q_rst); end
        rst = 1'b0;
        checks++; if (q_rst !== 1'b1)     begin errors++; $display("FAIL rstcap_arm got=%b expected=1", q_rst); end
        ticks(10);
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rstcap_no_push got=%0d expected=0", count); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        out_ready  = 1'b0;
        bank_delay = 2;
        for (int i = 0; i < 2; i++) begin
            bank_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        seen = 0;
        for (int i = 0; i < 200; i++) begin tick(); if (count === 3'd2) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_fill got=%0d expected=2", count); end
        ticks(5);
        bank_q.push_back(8'h12);
        exp_q.push_back(8'h12);
        seen = 0;
        for (int i = 0; i < 50; i++) begin tick(); if (q_ack === 8'hFF) begin seen = 1; break; end end
        ticks(2);
        // Now in the capture cycle: pop in the same cycle as the push.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (!seen || count !== 3'd2) begin errors++; $display("FAIL b2b_simul got=%0d expected=2", count); end
        out_ready = 1'b1;
        for (int i = 3; i < 10; i++) begin
            bank_q.push_back(8'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        seen = 0;
        for (int i = 0; i < 400; i++) begin tick(); if (exp_q.size() == 0 && count === 3'd0) begin seen = 1; break; end end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_wrap got=%0d left expected=0", exp_q.size()); end
        out_ready = 1'b0;
    endtask

`ifdef Q_SYNC_CAPTURE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bit seen;
        do_reset();
        for (int i = 0; i < 10 && q_rst === 1'b1; i++) tick();
        n = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin tick(); n++; if (err === 1'b1) begin seen = 1; break; end end
        checks++; if (!seen || n != 64) begin errors++; $display("FAIL timeout_cycle got=%0d expected=64", n); end
        checks++; if (q_rst !== 1'b1) begin errors++; $display("FAIL timeout_rearm got=%b expected=1", q_rst); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL timeout_no_push got=%0d expected=0", count); end
        ticks(150);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b expected=1", err); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b expected=0", err); end
    endtask
`else
    task automatic test_no_timeout();
        do_reset();
        ticks(200);
        checks++; if (err !== 1'b0)   begin errors++; $display("FAIL no_timeout_err got=%b expected=0", err); end
        checks++; if (q_rst !== 1'b0) begin errors++; $display("FAIL no_timeout_wait got=%b expected=0", q_rst); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_partial_ack();
        test_reset_capture();
        test_back_to_back();
`ifdef Q_SYNC_CAPTURE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/q_sync_capture.md
Name: q_sync_capture

Overview:
- Downstream consumer of a bank of W q_flop cells.
- Detects bank-wide completion (all ack bits high) through a synchronizer, captures the resolved word into a small synchronous FIFO, then re-arms the bank via its rst line.
- Bridges the self-timed Q-flop stage into the clocked pipeline with a valid/ready output.

Parameters:
- W, 8, number of q_flop cells in the bank / data width
- DEPTH, 4, FIFO entries (power of two, >=2)
- SYNC_STAGES, 2, flops in the all-ack synchronizer (>=2)
- ARM_CYCLES, 2, cycles q_rst is held high per re-arm (>=1)
- TIMEOUT, 64, cycles allowed in WAIT_DONE before forced re-arm (feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- q_ack  in  W  ack outputs of the q_flop bank (asynchronous to clk)
- q_out  in  W  out outputs of the q_flop bank
- q_rst  out  1  rst drive to every q_flop in the bank
- out_data  out  W  FIFO head word
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- count  out  $clog2(DEPTH)+1  current FIFO occupancy
- err  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- all_ack = &q_ack, passed through SYNC_STAGES flops; sync_ack is the last stage. No other q_* input is synchronized.
- FSM states: ARM, SETTLE, WAIT_DONE, CAPTURE, STALL.
- ARM: q_rst=1 for exactly ARM_CYCLES cycles, then go to SETTLE.
- SETTLE: q_rst=0. Wait for sync_ack==0 (bank sampling), then go to WAIT_DONE.
- WAIT_DONE: on sync_ack==1:
  - FIFO not full -> CAPTURE.
  - FIFO full -> STALL.
- CAPTURE: one cycle. Register q_out into the FIFO tail (push), then go to ARM. The word is stable because the bank holds out while ack is high and q_rst is low.
- STALL: hold q_rst=0, so the bank keeps its value. Go to CAPTURE on the first cycle the FIFO is not full.
- Latency:
  - sync_ack rise to out_valid = 2 cycles when the FIFO is empty (CAPTURE cycle + registered write).
  - q_ack completion to out_valid = SYNC_STAGES + 2 cycles.
- FIFO:
  - Registered storage with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - out_data is the head word; it is valid whenever out_valid=1 and stable until popped.
  - Simultaneous push and pop while full: not possible (CAPTURE requires not full).
  - Simultaneous push and pop otherwise: both take effect, count unchanged.
  - Pop while empty is ignored.
  - count never exceeds DEPTH.
- Reset (any cycle, including mid-capture):
  - State -> ARM with arm counter cleared; q_rst=1 during and for ARM_CYCLES after reset.
  - FIFO emptied: out_valid=0, count=0, out_data=0.
  - Synchronizer flops cleared to 0; err=0.
- sync_ack already 1 while in SETTLE: remain in SETTLE until it drops. No spurious capture.

Optional Feature:
- Macro: Q_SYNC_CAPTURE_TIMEOUT_EN.
- Defined:
  - Cycle counter runs in SETTLE and WAIT_DONE.
  - Reaching TIMEOUT -> set err (sticky until rst), discard the sample, go to ARM.
  - Counter clears on entering ARM.
- Undefined: no counter; err tied to 0; the FSM waits indefinitely.

Decomposition:
- Shared package q_pkg holds:
  - FSM state enum q_cap_state_t (ARM, SETTLE, WAIT_DONE, CAPTURE, STALL).
  - Default constants Q_SYNC_STAGES_DEF=2 and Q_ARM_CYCLES_DEF=2.
- One natural sub-module: q_sync_fifo (DEPTH x W synchronous FIFO with push/pop/count), reusable by later pipeline stages.
- The synchronizer stays inline.

Test Plan:
- Reset, then bank model asserts all q_ack 40 cycles after q_rst falls with q_out=8'hA5 -> q_rst high 2 cycles after reset release; out_valid rises SYNC_STAGES+2 cycles after ack; out_data=8'hA5; count=1; q_rst re-pulses for 2 cycles.
- out_ready=0, 5 completions with data 1..5, DEPTH=4 -> count=4; FSM holds STALL with q_rst=0. Raise out_ready for 1 cycle -> pops 1; word 5 captured next; popped order is 1,2,3,4,5.
- Only 7 of 8 q_ack bits high -> no capture and count stays 0. Raise the 8th bit -> capture occurs.
- rst asserted during CAPTURE cycle -> FIFO empty next cycle, out_valid=0, state ARM, q_rst=1.
- Simultaneous pop and push with count=2 -> count stays 2; data order preserved across pointer wrap (run 10 words through DEPTH=4).
- With Q_SYNC_CAPTURE_TIMEOUT_EN and TIMEOUT=64, bank never acks -> err=1 at cycle 64 of SETTLE; FSM returns to ARM; no word pushed; err stays 1 until rst.
